// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared encodings for the load/store front end: funct3 codes, FSM states,
// byte-lane geometry and small decode helpers.
package lsu_dmem_ctrl_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int OFF_W     = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Right-justified lane mask for an access size taken from funct3[1:0].
  function automatic logic [NUM_LANES-1:0] size_mask(input logic [1:0] size);
    logic [NUM_LANES-1:0] mask;
    case (size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_lane_align.sv
// Combinational lane steering: store masks/data over an 8-byte window and
// load extraction with sign/zero extension.
module lsu_lane_align
  import lsu_dmem_ctrl_pkg::*;
(
  input  logic [2:0]                  funct3,
  input  logic [OFF_W-1:0]            off,
  input  logic [31:0]                 wdata,
  input  logic [31:0]                 word0,
  input  logic [31:0]                 word1,
  output logic [NUM_LANES-1:0]        be_lo,
  output logic [NUM_LANES-1:0]        be_hi,
  output logic [31:0]                 wd_lo,
  output logic [31:0]                 wd_hi,
  output logic                        crosses,
  output logic [31:0]                 load_data
);

  logic [2*NUM_LANES-1:0]        be8;
  logic [2*NUM_LANES*LANE_W-1:0] wd64;
  logic [2*NUM_LANES*LANE_W-1:0] wd64_masked;
  logic [31:0]                   rd_shift;
  logic                          sign_ext;

  assign be8  = {{NUM_LANES{1'b0}}, size_mask(funct3[1:0])} << off;
  assign wd64 = {32'h0, wdata} << {off, 3'b000};

  // Lanes outside the access carry zero so the memory never sees stale bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 2*NUM_LANES; gi++) begin : g_lane
      assign wd64_masked[gi*LANE_W +: LANE_W] = be8[gi] ? wd64[gi*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  assign be_lo   = be8[NUM_LANES-1:0];
  assign be_hi   = be8[2*NUM_LANES-1:NUM_LANES];
  assign wd_lo   = wd64_masked[31:0];
  assign wd_hi   = wd64_masked[63:32];
  assign crosses = |be_hi;

  assign rd_shift = 32'({word1, word0} >> {off, 3'b000});
  assign sign_ext = ~funct3[2];

  always_comb begin
    load_data = '0;
    case (funct3[1:0])
      2'b00:   load_data = {{24{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_data = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store front end for data memory port 1: registers a request, issues
// one or two word accesses, then returns the extended load data or an error.
module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [DWIDTH-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DWIDTH-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [AWIDTH-1:0]    mem_addr,
  output logic [NUM_LANES-1:0] mem_wbe,
  output logic [DWIDTH-1:0]    mem_wdata,
  output logic                 mem_wen,
  input  logic [DWIDTH-1:0]    mem_rdata
);

  lsu_state_t          state_reg;
  logic                we_reg;
  logic [2:0]          f3_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [AWIDTH-1:0]   waddr_reg;
  logic [DWIDTH-1:0]   wdata_reg;
  logic [DWIDTH-1:0]   word0_reg;
  logic [DWIDTH-1:0]   word1_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [DWIDTH-1:0]   rsp_rdata_reg;

  logic                legal;
  logic                split;
  logic [NUM_LANES-1:0] be_lo;
  logic [NUM_LANES-1:0] be_hi;
  logic [DWIDTH-1:0]   wd_lo;
  logic [DWIDTH-1:0]   wd_hi;
  logic                crosses;
  logic [DWIDTH-1:0]   load_data;
  logic                unused_addr_bits;

  // Only the in-range word address and byte offset matter.
  assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

  lsu_lane_align u_align (
    .funct3    (f3_reg),
    .off       (off_reg),
    .wdata     (wdata_reg),
    .word0     (word0_reg),
    .word1     (word1_reg),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wd_lo     (wd_lo),
    .wd_hi     (wd_hi),
    .crosses   (crosses),
    .load_data (load_data)
  );

  assign legal = f3_legal(we_reg, f3_reg);
  // Illegal requests never take the second access even if their size field would cross.
  assign split = legal & crosses;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      f3_reg        <= '0;
      off_reg       <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      word0_reg     <= '0;
      word1_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            f3_reg    <= req_funct3;
            off_reg   <= req_addr[OFF_W-1:0];
            waddr_reg <= req_addr[AWIDTH+1:2];
            wdata_reg <= req_wdata;
            word1_reg <= '0;
            state_reg <= ST_ACC0;
          end
        end
        ST_ACC0: begin
          word0_reg <= mem_rdata;
          state_reg <= split ? ST_ACC1 : ST_RESP;
        end
        ST_ACC1: begin
          word1_reg <= mem_rdata;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= ~legal;
          rsp_rdata_reg <= (legal && !we_reg) ? load_data : '0;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded from registered state only, so reset silences it at once.
  always_comb begin
    mem_addr  = '0;
    mem_wbe   = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    case (state_reg)
      ST_ACC0: begin
        mem_addr = waddr_reg;
        if (legal) mem_wbe = be_lo;
        if (legal && we_reg) begin
          mem_wdata = wd_lo;
          mem_wen   = |be_lo;
        end
      end
      ST_ACC1: begin
        mem_addr = waddr_reg + AWIDTH'(1);
        if (legal) mem_wbe = be_hi;
        if (legal && we_reg) begin
          mem_wdata = wd_hi;
          mem_wen   = |be_hi;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed vector table, reset
// mid-store sequence, and random traffic against a byte-level memory model.
module tb_lsu_dmem_ctrl;

  localparam int AWIDTH = 12;
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [AWIDTH-1:0] mem_addr;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wbe    (mem_wbe),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata)
  );

  // Data memory port 1: asynchronous read, byte-enabled write on the rising edge.
  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model: flat byte array addressed by the in-range byte address.
  logic [7:0] ref_mem [NBYTES];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  function automatic bit ref_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic int ref_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int byte_index(input logic [31:0] addr, input int i);
    return (int'(addr[AWIDTH+1:0]) + i) % NBYTES;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int nb;
    v  = '0;
    nb = ref_bytes(f3);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[byte_index(addr, i)];
    if (f3 == 3'b000)      v = {{24{v[7]}}, v[7:0]};
    else if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL txn %0d %s got=%h expected=%h", txn, name, got, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] val);
    mem[w] = val;
    for (int i = 0; i < 4; i++) ref_mem[4*w + i] = val[8*i +: 8];
  endtask

  // Per-cycle record of the memory port from accept+1 until the response.
  logic [AWIDTH-1:0] tr_addr [8];
  logic [3:0]        tr_wbe  [8];
  logic [31:0]       tr_wd   [8];
  logic              tr_wen  [8];
  logic [31:0]       got_rdata;
  logic              got_err;
  int                got_lat;

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          legal;
    int          nb, off, exp_lat, n, pos;
    logic [AWIDTH-1:0] exp_a [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    logic [31:0] exp_rd;
    legal   = ref_legal(we, f3);
    nb      = ref_bytes(f3);
    off     = int'(addr[1:0]);
    exp_lat = (legal && (off + nb > 4)) ? 3 : 2;
    exp_rd  = (legal && !we) ? ref_load(f3, addr) : 32'h0;
    exp_a[0] = addr[AWIDTH+1:2];
    exp_a[1] = AWIDTH'((int'(addr[AWIDTH+1:2]) + 1) % DEPTH);
    for (int k = 0; k < 2; k++) begin
      exp_be[k] = '0;
      exp_wd[k] = '0;
    end
    if (legal && we)
      for (int i = 0; i < nb; i++) begin
        pos = off + i;
        exp_be[pos / 4][pos % 4]        = 1'b1;
        exp_wd[pos / 4][8*(pos%4) +: 8] = wd[8*i +: 8];
      end

    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    n = 0;
    while (!rsp_valid && n < 8) begin
      tr_addr[n] = mem_addr;
      tr_wbe[n]  = mem_wbe;
      tr_wd[n]   = mem_wdata;
      tr_wen[n]  = mem_wen;
      @(posedge clk);
      #1;
      n++;
    end
    got_lat   = n;
    got_rdata = rsp_rdata;
    got_err   = rsp_err;

    check("latency", 32'(got_lat), 32'(exp_lat));
    check("rsp_rdata", got_rdata, exp_rd);
    check("rsp_err", 32'(got_err), 32'(!legal));
    if (got_lat == exp_lat) begin
      for (int k = 0; k < exp_lat - 1; k++) begin
        check($sformatf("mem_addr%0d", k), 32'(tr_addr[k]), 32'(exp_a[k]));
        check($sformatf("mem_wen%0d", k), 32'(tr_wen[k]), 32'(legal && we));
        if (legal && we) begin
          check($sformatf("mem_wbe%0d", k), 32'(tr_wbe[k]), 32'(exp_be[k]));
          check($sformatf("mem_wdata%0d", k), tr_wd[k], exp_wd[k]);
        end
      end
      check("mem_wen_resp", 32'(tr_wen[exp_lat-1]), 32'd0);
    end

    @(posedge clk);
    #1;
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rsp_hold", rsp_rdata, exp_rd);

    if (legal && we)
      for (int i = 0; i < nb; i++) ref_mem[byte_index(addr, i)] = wd[8*i +: 8];

    $display("txn %0d we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             txn, we, f3, addr, wd, got_rdata, got_err, got_lat);
    txn++;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_wbe0;
    logic [31:0] exp_wd0;
    logic [3:0]  exp_wbe1;
    logic [31:0] exp_wd1;
  } vec_t;

  vec_t vecs [13];

  initial begin
    bit          seen;
    logic [31:0] rw;
    int          bad;

    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h4433_2211, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_000B, 32'h0,         32'hFFFF_FF88, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_000B, 32'h0,         32'h0000_0088, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0,         32'h0000_4433, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h1234_56AA, 32'h0,         1'b0, 2, 4'h2, 32'h0000_AA00, 4'h0, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h4433_AA11, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h6655_4433, 1'b0, 3, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0007, 32'h0000_BEEF, 32'h0,         1'b0, 3, 4'h8, 32'hEF00_0000, 4'h1, 32'h0000_00BE};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_3FFE, 32'h0,         32'hF00D_CAFE, 1'b0, 3, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[9]  = '{1'b1, 3'b011, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,         1'b1, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[10] = '{1'b0, 3'b110, 32'h0000_0001, 32'h0,         32'h0,         1'b1, 2, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b101, 32'h0000_0003, 32'h0,         32'h0000_110B, 1'b0, 3, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b001, 32'hABCD_000A, 32'h0,         32'hFFFF_8877, 1'b0, 2, 4'h0, 32'h0,         4'h0, 32'h0};

    for (int w = 0; w < DEPTH; w++) preload(w, 32'h0);
    preload(0,         32'h0BAD_F00D);
    preload(1,         32'h4433_2211);
    preload(2,         32'h8877_6655);
    preload(DEPTH - 1, 32'hCAFE_BABE);

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_mem_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wbe", 32'(mem_wbe), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'h0);

    for (int v = 0; v < 13; v++) begin
      do_req(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata);
      check("tbl_rdata", got_rdata, vecs[v].exp_rdata);
      check("tbl_err", 32'(got_err), 32'(vecs[v].exp_err));
      check("tbl_lat", 32'(got_lat), 32'(vecs[v].exp_lat));
      if (vecs[v].we && !vecs[v].exp_err) begin
        check("tbl_wbe0", 32'(tr_wbe[0]), 32'(vecs[v].exp_wbe0));
        check("tbl_wd0", tr_wd[0], vecs[v].exp_wd0);
        if (vecs[v].exp_lat == 3) begin
          check("tbl_wbe1", 32'(tr_wbe[1]), 32'(vecs[v].exp_wbe1));
          check("tbl_wd1", tr_wd[1], vecs[v].exp_wd1);
        end
      end
    end
    check("wrap_addr0", 32'(mem_addr), 32'd0);

    // Reset while in the second access of a split word store.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0005;
    req_wdata  = 32'hDDCC_BBAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_acc0_wen", 32'(mem_wen), 32'd1);
    check("rst_acc0_addr", 32'(mem_addr), 32'd1);
    @(posedge clk);
    #1;
    check("rst_acc1_wen", 32'(mem_wen), 32'd1);
    check("rst_acc1_addr", 32'(mem_addr), 32'd2);
    reset = 1'b1;
    #1;
    check("rst_wen_drop", 32'(mem_wen), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem1", mem[1], 32'hCCBB_AA11);
    check("rst_mem2", mem[2], 32'h8877_66BE);
    ref_mem[5] = 8'hAA;
    ref_mem[6] = 8'hBB;
    ref_mem[7] = 8'hCC;
    $display("txn %0d reset during split SW 0x5 -> mem1=%h mem2=%h", txn, mem[1], mem[2]);
    txn++;

    // Random traffic concentrated on a few words, including the top-of-memory wrap.
    for (int r = 0; r < 300; r++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_C000;
      if ($urandom_range(0, 7) == 0) a = a | (32'h3FF8 + 32'($urandom_range(0, 7)));
      else                           a = a | 32'($urandom_range(0, 63));
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end

    bad = 0;
    for (int w = 0; w < DEPTH; w++) begin
      rw = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      if (mem[w] !== rw) begin
        if (bad == 0) $display("FAIL final_mem word %0d got=%h expected=%h", w, mem[w], rw);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
